// File: rtl/seg7_to_time.sv
`default_nettype none
// ============================================================================
// Module   : seg7_to_time
// Purpose  : Converts six 7-segment digit patterns (hh:mm:ss) back into binary
//            hours, minutes and seconds. Each digit is looked up to BCD, then
//            the two-digit BCD fields are turned into binary with reverse
//            double-dabble and range-checked before the outputs are updated.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_to_time #(
    parameter int S_MAX = 59,
    parameter int M_MAX = 59,
    parameter int H_MAX = 23
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] seg_s1,
    input  logic [6:0] seg_s2,
    input  logic [6:0] seg_m1,
    input  logic [6:0] seg_m2,
    input  logic [6:0] seg_h1,
    input  logic [6:0] seg_h2,
    input  logic       d_in_ready,
    output logic [5:0] time_s,
    output logic [5:0] time_m,
    output logic [5:0] time_h,
    output logic       ready,
    output logic       error,
    output logic       busy
);

    localparam logic [6:0] c_s_max = 7'(S_MAX);
    localparam logic [6:0] c_m_max = 7'(M_MAX);
    localparam logic [6:0] c_h_max = 7'(H_MAX);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DECODE  = 3'd1,
        S_CONVERT = 3'd2,
        S_CHECK   = 3'd3,
        S_COMMIT  = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t     r_state;
    // Captured patterns, ordered s1, s2, m1, m2, h1, h2 (ones before tens).
    logic [6:0] r_seg [6];
    // Per field {bcd[7:0], bin[7:0]}; the extra binary bit lets all eight BCD
    // bits pass fully into the binary half over the eight shift iterations.
    logic [15:0] r_sr [3];
    logic [2:0] r_iter;
    logic       r_digit_err;
    logic       r_err;
    logic [5:0] r_time_s;
    logic [5:0] r_time_m;
    logic [5:0] r_time_h;
    logic       r_ready;
    logic       r_error;
    logic       r_busy;

    logic [4:0]  w_lk [6];
    logic [15:0] w_step [3];

    // Pattern to {illegal, bcd digit}; blank reads as zero so a blinked-off
    // display still converts.
    function automatic logic [4:0] f_lookup(input logic [6:0] pat);
        logic [4:0] res;
        case (pat)
            7'h00:   res = {1'b0, 4'd0};
            7'h3F:   res = {1'b0, 4'd0};
            7'h06:   res = {1'b0, 4'd1};
            7'h5B:   res = {1'b0, 4'd2};
            7'h4F:   res = {1'b0, 4'd3};
            7'h66:   res = {1'b0, 4'd4};
            7'h6D:   res = {1'b0, 4'd5};
            7'h7D:   res = {1'b0, 4'd6};
            7'h07:   res = {1'b0, 4'd7};
            7'h7F:   res = {1'b0, 4'd8};
            7'h6F:   res = {1'b0, 4'd9};
            default: res = {1'b1, 4'd0};
        endcase
        return res;
    endfunction

    // One reverse double-dabble iteration: shift right, then correct nibbles.
    function automatic logic [15:0] f_step(input logic [15:0] v);
        logic [15:0] t;
        t = v >> 1;
        if (t[15:12] >= 4'd8) t[15:12] = t[15:12] - 4'd3;
        if (t[11:8]  >= 4'd8) t[11:8]  = t[11:8]  - 4'd3;
        return t;
    endfunction

    // Digit lookups and next conversion step for all fields in parallel.
    always_comb begin
        for (int i = 0; i < 6; i++) begin
            w_lk[i] = f_lookup(r_seg[i]);
        end
        for (int j = 0; j < 3; j++) begin
            w_step[j] = f_step(r_sr[j]);
        end
    end

    // Request sequencer: capture, decode, convert, check, commit, report.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_iter      <= 3'd0;
            r_digit_err <= 1'b0;
            r_err       <= 1'b0;
            r_time_s    <= 6'd0;
            r_time_m    <= 6'd0;
            r_time_h    <= 6'd0;
            r_ready     <= 1'b0;
            r_error     <= 1'b0;
            r_busy      <= 1'b0;
            for (int i = 0; i < 6; i++) r_seg[i] <= 7'd0;
            for (int j = 0; j < 3; j++) r_sr[j] <= 16'd0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (d_in_ready) begin
                        r_seg[0] <= seg_s1;
                        r_seg[1] <= seg_s2;
                        r_seg[2] <= seg_m1;
                        r_seg[3] <= seg_m2;
                        r_seg[4] <= seg_h1;
                        r_seg[5] <= seg_h2;
                        r_busy   <= 1'b1;
                        r_state  <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    for (int j = 0; j < 3; j++) begin
                        r_sr[j] <= {w_lk[2*j+1][3:0], w_lk[2*j][3:0], 8'h00};
                    end
                    r_digit_err <= w_lk[0][4] | w_lk[1][4] | w_lk[2][4] |
                                   w_lk[3][4] | w_lk[4][4] | w_lk[5][4];
                    r_iter      <= 3'd0;
                    r_state     <= S_CONVERT;
                end
                S_CONVERT: begin
                    for (int j = 0; j < 3; j++) r_sr[j] <= w_step[j];
                    r_iter <= r_iter + 3'd1;
                    if (r_iter == 3'd7) r_state <= S_CHECK;
                end
                S_CHECK: begin
                    // Compare the full 7-bit values so 64..99 cannot alias.
                    r_err   <= r_digit_err |
                               (r_sr[0][6:0] > c_s_max) |
                               (r_sr[1][6:0] > c_m_max) |
                               (r_sr[2][6:0] > c_h_max);
                    r_state <= S_COMMIT;
                end
                S_COMMIT: begin
                    if (!r_err) begin
                        r_time_s <= r_sr[0][5:0];
                        r_time_m <= r_sr[1][5:0];
                        r_time_h <= r_sr[2][5:0];
                    end
                    r_error <= r_err;
                    r_ready <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    if (d_in_ready) begin
                        r_seg[0] <= seg_s1;
                        r_seg[1] <= seg_s2;
                        r_seg[2] <= seg_m1;
                        r_seg[3] <= seg_m2;
                        r_seg[4] <= seg_h1;
                        r_seg[5] <= seg_h2;
                        r_state  <= S_DECODE;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign time_s = r_time_s;
    assign time_m = r_time_m;
    assign time_h = r_time_h;
    assign ready  = r_ready;
    assign error  = r_error;
    assign busy   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_seg7_to_time.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_to_time
// Purpose  : Scoreboard bench for seg7_to_time. A reference model computes the
//            expected face from digit values; a monitor compares on ready.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_to_time;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] seg_s1 = '0, seg_s2 = '0, seg_m1 = '0, seg_m2 = '0, seg_h1 = '0, seg_h2 = '0;
    logic       d_in_ready = 1'b0;
    logic [5:0] time_s, time_m, time_h;
    logic       ready, error, busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [6:0] c_seg [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    typedef struct {
        bit err;
        int h;
        int m;
        int s;
        int cyc;
    } exp_t;
    exp_t q[$];
    exp_t e;

    // Model's view of the currently held face.
    int mh = 0, mm = 0, ms = 0;

    seg7_to_time #(.S_MAX(59), .M_MAX(59), .H_MAX(23)) dut (
        .clk(clk), .reset(reset),
        .seg_s1(seg_s1), .seg_s2(seg_s2), .seg_m1(seg_m1),
        .seg_m2(seg_m2), .seg_h1(seg_h1), .seg_h2(seg_h2),
        .d_in_ready(d_in_ready),
        .time_s(time_s), .time_m(time_m), .time_h(time_h),
        .ready(ready), .error(error), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Digit value of a pattern, -1 when illegal.
    function automatic int dec(input logic [6:0] p);
        if (p == 7'h00) return 0;
        for (int i = 0; i < 10; i++) if (c_seg[i] == p) return i;
        return -1;
    endfunction

    function automatic logic [6:0] rpat(input int hi);
        int r;
        r = int'($urandom_range(0, 31));
        if (r == 0) return 7'($urandom);
        if (r == 1) return 7'h00;
        return c_seg[$urandom_range(0, hi)];
    endfunction

    // Called at a negedge: presents a request for the next edge.
    task automatic send(input logic [6:0] h2, h1, m2, m1, s2, s1);
        int d[6];
        bit bad;
        int vh, vm, vs;
        exp_t x;
        d[0] = dec(h2); d[1] = dec(h1); d[2] = dec(m2);
        d[3] = dec(m1); d[4] = dec(s2); d[5] = dec(s1);
        bad = 1'b0;
        foreach (d[i]) if (d[i] < 0) bad = 1'b1;
        vh = d[0] * 10 + d[1];
        vm = d[2] * 10 + d[3];
        vs = d[4] * 10 + d[5];
        x.err = bad || vh > 23 || vm > 59 || vs > 59;
        if (!x.err) begin
            mh = vh; mm = vm; ms = vs;
        end
        x.h = mh; x.m = mm; x.s = ms;
        x.cyc = cyc + 12;
        q.push_back(x);
        seg_h2 = h2; seg_h1 = h1; seg_m2 = m2; seg_m1 = m1; seg_s2 = s2; seg_s1 = s1;
        d_in_ready = 1'b1;
        @(negedge clk);
        d_in_ready = 1'b0;
        seg_h2 = 7'($urandom); seg_h1 = 7'($urandom); seg_m2 = 7'($urandom);
        seg_m1 = 7'($urandom); seg_s2 = 7'($urandom); seg_s1 = 7'($urandom);
    endtask

    // Returns at the negedge where ready is high, or flags a timeout.
    task automatic wait_done();
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (ready !== 1'b1) begin
            chk("ready_timeout", 0, 1);
            q.delete();
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (reset === 1'b1 && ready === 1'b1) begin
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_ready: got ready=1, expected no pending request (cycle %0d)", cyc);
            end else begin
                e = q.pop_front();
                chk("time_h", int'(time_h), e.h);
                chk("time_m", int'(time_m), e.m);
                chk("time_s", int'(time_s), e.s);
                chk("error", int'(error), int'(e.err));
                chk("latency", cyc, e.cyc);
                chk("busy_in_ready", int'(busy), 1);
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_time_s", int'(time_s), 0);
        chk("rst_time_m", int'(time_m), 0);
        chk("rst_time_h", int'(time_h), 0);
        chk("rst_ready", int'(ready), 0);
        chk("rst_error", int'(error), 0);
        chk("rst_busy", int'(busy), 0);
        @(negedge clk);
        reset = 1'b1;
        idle(2);

        // 12:34:56
        send(7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D);
        wait_done();
        idle(3);
        chk("busy_idle", int'(busy), 0);

        // 23:59:59 then 00:00:00 back-to-back in the DONE cycle
        send(7'h5B, 7'h4F, 7'h6D, 7'h6F, 7'h6D, 7'h6F);
        wait_done();
        send(7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F);
        wait_done();
        idle(2);

        // 10:20:30 then illegal minutes-ones
        send(7'h06, 7'h3F, 7'h5B, 7'h3F, 7'h4F, 7'h3F);
        wait_done();
        idle(1);
        send(7'h06, 7'h3F, 7'h5B, 7'h01, 7'h4F, 7'h3F);
        wait_done();
        idle(1);
        // hours 24, seconds 60, hours 23
        send(7'h5B, 7'h66, 7'h3F, 7'h06, 7'h3F, 7'h06);
        wait_done();
        idle(1);
        send(7'h3F, 7'h06, 7'h3F, 7'h06, 7'h7D, 7'h3F);
        wait_done();
        idle(1);
        send(7'h5B, 7'h4F, 7'h3F, 7'h06, 7'h3F, 7'h06);
        wait_done();
        idle(1);
        // all blank
        send(7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00);
        wait_done();
        idle(1);

        // Second request during CONVERT is ignored
        send(7'h06, 7'h06, 7'h06, 7'h06, 7'h06, 7'h06);
        idle(3);
        seg_h2 = 7'h5B; seg_h1 = 7'h5B; seg_m2 = 7'h5B;
        seg_m1 = 7'h5B; seg_s2 = 7'h5B; seg_s1 = 7'h5B;
        d_in_ready = 1'b1;
        @(negedge clk);
        d_in_ready = 1'b0;
        wait_done();
        idle(15);

        // Randomized requests with random gaps (0 = back-to-back)
        for (int k = 0; k < 40; k++) begin
            send(rpat(2), rpat(9), rpat(6), rpat(9), rpat(6), rpat(9));
            wait_done();
            idle(int'($urandom_range(0, 3)));
        end
        idle(2);

        // Reset mid-request aborts it
        send(7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D);
        idle(4);
        reset = 1'b0;
        @(posedge clk);
        #1;
        q.delete();
        mh = 0; mm = 0; ms = 0;
        chk("abort_time_s", int'(time_s), 0);
        chk("abort_time_m", int'(time_m), 0);
        chk("abort_time_h", int'(time_h), 0);
        chk("abort_ready", int'(ready), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_error", int'(error), 0);
        @(negedge clk);
        reset = 1'b1;
        idle(16);

        // Still functional after the abort
        send(7'h7F, 7'h3F, 7'h6F, 7'h6F, 7'h06, 7'h07);
        wait_done();
        idle(15);
        chk("queue_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
